// File: rtl/sort_pkg.sv
// sort_pkg -- shared definitions for the sorter stimulus transmitter.
//
// Contents:
//   DATA_W        : sample width of the sorter stream
//   LFSR_TAPS     : feedback mask of the right-shifting Galois LFSR
//   LFSR_ZERO_SUB : value loaded instead of an all-zero seed (lock-up state)
//   state_e       : transmitter FSM states
//   lfsr_seed()   : seed with zero substitution applied
//   lfsr_step()   : one Galois LFSR step
package sort_pkg;

    localparam int         DATA_W        = 8;
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        DONE
    } state_e;

    // An all-zero state would never leave zero, so it is replaced.
    function automatic logic [7:0] lfsr_seed(input logic [7:0] s);
        return (s == 8'h00) ? LFSR_ZERO_SUB : s;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/sort_lfsr8.sv
// sort_lfsr8 -- 8-bit right-shifting Galois LFSR with synchronous load.
//
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (state -> LFSR_ZERO_SUB)
//   load_i  : load seed_i (zero seed substituted), has priority over en_i
//   seed_i  : seed value
//   en_i    : advance one step
//   state_o : current LFSR state
module sort_lfsr8
    import sort_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    input  logic       en_i,
    output logic [7:0] state_o
);

    logic [7:0] state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LFSR_ZERO_SUB;
        end else if (load_i) begin
            state_q <= lfsr_seed(seed_i);
        end else if (en_i) begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/sort_stream_tx.sv
// sort_stream_tx -- stimulus transmitter and return-path collector for the
// 8-bit signed sorter. A start pulse sends FRAME_LEN LFSR bytes on tx_*,
// then the sorted stream is collected from rx_* and completion reported.
//
// Optional macro SORT_TX_CHECK_EN compiles in the return-path checker
// (order and sum); without it err_order/err_sum are tied low.
//
// Parameters: FRAME_LEN (2..255) values per frame,
//             TIMEOUT   (>=2) silent-cycle budget in WAIT/RECV.
// Ports:
//   CLK, RESET (async, active low)
//   start, seed           : frame request and LFSR seed
//   tx_data, tx_valid     : stream to the sorter input
//   rx_data, rx_valid     : stream from the sorter output
//   busy, done, timeout   : status (done is a one-cycle pulse)
//   err_order, err_sum    : checker results, sticky per frame
module sort_stream_tx
    import sort_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic [7:0]               seed,
    output logic signed [DATA_W-1:0] tx_data,
    output logic                     tx_valid,
    input  logic signed [DATA_W-1:0] rx_data,
    input  logic                     rx_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic                     err_order,
    output logic                     err_sum
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [TMR_W-1:0]          tmr_q;
    logic signed [DATA_W-1:0]  tx_data_q;
    logic                      tx_valid_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      timeout_q;
    logic [7:0]                lfsr_state;
    logic                      start_ok;

    // A start coinciding with the done pulse belongs to the finished frame
    // and is dropped.
    assign start_ok = (state_q == IDLE) && start && !done_q;

    sort_lfsr8 u_lfsr (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .load_i  (start_ok),
        .seed_i  (seed),
        .en_i    (state_q == SEND),
        .state_o (lfsr_state)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmr_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q    <= SEND;
                        tx_data_q  <= lfsr_seed(seed);
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        timeout_q  <= 1'b0;
                        cnt_q      <= '0;
                        tmr_q      <= '0;
                    end
                end
                SEND: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= WAIT;
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                        cnt_q      <= '0;
                        // Timer starts at 1 so that done lands right after
                        // TIMEOUT silent cycles (the DONE cycle is counted).
                        tmr_q      <= TMR_W'(1);
                    end else begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        tx_data_q <= lfsr_step(lfsr_state);
                    end
                end
                WAIT: begin
                    if (rx_valid) begin
                        state_q <= RECV;
                        cnt_q   <= CNT_W'(1);
                        tmr_q   <= TMR_W'(1);
                    end else if (tmr_q == TMR_LAST) begin
                        state_q   <= DONE;
                        timeout_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        tmr_q <= TMR_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (tmr_q == TMR_LAST) begin
                        state_q   <= DONE;
                        timeout_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;

`ifdef SORT_TX_CHECK_EN
    localparam int ACC_W = DATA_W + $clog2(FRAME_LEN);

    logic signed [ACC_W-1:0]  acc_tx_q;
    logic signed [ACC_W-1:0]  acc_rx_q;
    logic signed [DATA_W-1:0] prev_q;
    logic                     err_order_q;
    logic                     err_sum_q;
    logic signed [ACC_W-1:0]  tx_ext;
    logic signed [ACC_W-1:0]  rx_ext;

    assign tx_ext = {{(ACC_W - DATA_W){tx_data_q[DATA_W-1]}}, tx_data_q};
    assign rx_ext = {{(ACC_W - DATA_W){rx_data[DATA_W-1]}}, rx_data};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc_tx_q    <= '0;
            acc_rx_q    <= '0;
            prev_q      <= '0;
            err_order_q <= 1'b0;
            err_sum_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                acc_tx_q    <= '0;
                acc_rx_q    <= '0;
                prev_q      <= '0;
                err_order_q <= 1'b0;
                err_sum_q   <= 1'b0;
            end
            // tx_data_q holds the beat being presented in every SEND cycle.
            if (state_q == SEND) begin
                acc_tx_q <= acc_tx_q + tx_ext;
            end
            if ((state_q == WAIT || state_q == RECV) && rx_valid) begin
                acc_rx_q <= acc_rx_q + rx_ext;
                prev_q   <= rx_data;
                if (state_q == RECV && rx_data < prev_q) begin
                    err_order_q <= 1'b1;
                end
            end
            if (state_q == DONE && (timeout_q || acc_tx_q != acc_rx_q)) begin
                err_sum_q <= 1'b1;
            end
        end
    end

    assign err_order = err_order_q;
    assign err_sum   = err_sum_q;
`else
    assign err_order = 1'b0;
    assign err_sum   = 1'b0;
`endif

endmodule

// File: doc/sort_stream_tx.md
# sort_stream_tx

Stimulus transmitter and return-path collector for the 8-bit signed number sorter. On a start pulse it generates one frame of pseudo-random signed bytes from an 8-bit LFSR and drives it onto the sorter's input stream (`tx_data`/`tx_valid`). It then collects the sorter's output stream (`rx_data`/`rx_valid`) and reports frame completion. It replaces the behavioural pattern generator so that the sorter can be exercised on-chip or in gate-level simulation.

## Interface
Parameters:
- `FRAME_LEN`, 8: values per frame; sorter frame size; legal range 2..255.
- `TIMEOUT`, 1024: maximum cycles spent in WAIT/RECV without an `rx_valid` beat.

Ports:
- `CLK` in 1: single clock; all logic is rising-edge.
- `RESET` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to send a frame; ignored unless in IDLE.
- `seed` in 8: LFSR seed, sampled on an accepted `start`.
- `tx_data` out 8 signed: value to the sorter `in`.
- `tx_valid` out 1: to the sorter `in_valid`.
- `rx_data` in 8 signed: from the sorter `out`.
- `rx_valid` in 1: from the sorter `out_valid`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `timeout` out 1: set at frame end if the timeout fired; held until the next accepted `start`.
- `err_order` out 1: checker result, sticky per frame.
- `err_sum` out 1: checker result, sticky per frame.

## Operation
- FSM: IDLE → SEND → WAIT → RECV → DONE → IDLE.
- **IDLE**
  - `start`=1: load the LFSR with `seed`; `seed`=0 loads 8'h01.
  - Clears `timeout`, `err_*`, the counters and the accumulators; goes to SEND.
- **SEND**
  - Exactly `FRAME_LEN` consecutive cycles with `tx_valid`=1. There are no gaps and the sorter gives no backpressure.
  - `tx_data` = current LFSR state as two's complement, so the first beat equals the seed.
  - The LFSR advances every SEND cycle. It is Galois, right-shift: next = (s>>1) ^ (s[0] ? 8'hB8 : 0).
  - After the last beat, go to WAIT.
- **WAIT**
  - The first `rx_valid` beat is accepted as beat 0 and the FSM goes to RECV.
  - If `TIMEOUT` cycles pass with no beat: set `timeout`, go to DONE.
- **RECV**
  - Accepts each `rx_valid` beat and counts it.
  - When the count reaches `FRAME_LEN`, go to DONE.
  - The idle-cycle counter restarts on every beat; on expiry: set `timeout`, go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `rx_valid` in IDLE, SEND or DONE is ignored, with no side effects.
- `start` while `busy` is ignored. `start` in the same cycle as DONE is ignored; it is accepted from IDLE only.
- Counters are `$clog2(FRAME_LEN+1)` bits wide and saturate-free by construction.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0, `timeout`=0, `err_order`=0, `err_sum`=0, FSM=IDLE, LFSR=8'h01.
- Reset is asynchronous. Asserting it mid-frame drops `tx_valid` immediately, with no partial frame completion.
- All outputs are registered.
- `start` sampled high at edge t → `tx_valid`=1 from edge t+1 through edge t+`FRAME_LEN`.
- `busy` rises at edge t+1.
- The last accepted rx beat at edge r → `done`=1 between edges r+1 and r+2.
- `err_*` and `timeout` are valid when `done`=1 and hold until the next accepted `start`.

## Configuration
- **`SORT_TX_CHECK_EN` defined:** the return-path checker is compiled in.
  - `err_order` sets if any accepted beat is less than the previous beat (signed compare).
  - `err_sum` sets at DONE if the signed sum of tx values ≠ signed sum of rx values. Accumulators are 8+`$clog2(FRAME_LEN)` bits, sign-extended.
  - A timeout also sets `err_sum`, because the frame is incomplete.
- **Not defined:** no comparator or accumulators are built. `err_order` and `err_sum` are tied to 0; the FSM, `done` and `timeout` are unchanged.

## Structure
- Package `sort_pkg`:
  - state enum (IDLE, SEND, WAIT, RECV, DONE);
  - `LFSR_TAPS`=8'hB8;
  - `DATA_W`=8;
  - `LFSR_ZERO_SUB`=8'h01.
- Sub-module `sort_lfsr8`: load/enable, seed-zero substitution, state output.
- The FSM, counters and checker live in `sort_stream_tx`.

## Test plan
1. Seed 8'hA5, `FRAME_LEN`=8, `start` pulse → `tx_valid` high for exactly 8 cycles; first beats A5, EA, 75, 82; `busy` high from the next edge.
2. The bench loops back the 8 tx values sorted ascending, contiguous, 3 cycles after SEND ends → `done` one cycle after the 8th beat; `err_order`=0, `err_sum`=0, `timeout`=0.
3. Same values returned with beats 2 and 3 swapped → `err_order`=1, `err_sum`=0 (with `SORT_TX_CHECK_EN`); both 0 without it.
4. Sorted return with one value +1 → `err_sum`=1, `err_order`=0.
5. No `rx_valid` after SEND, `TIMEOUT`=16 → `done` and `timeout`=1 on the 17th cycle after SEND ends. A second `start` clears `timeout`.
6. `RESET` asserted low at the 4th SEND beat → `tx_valid` and `busy` drop asynchronously. After release, `start` with seed 0 → first beat 8'h01.
